// File: rtl/seg_scan_controller_if.sv
// Load/value request and scanned display outputs of seg_scan_controller.
interface seg_scan_controller_if;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic [3:0] digit;
  logic [3:0] anode;

  modport master (output value, output load, input busy, input digit, input anode);
  modport slave  (input value, input load, output busy, output digit, output anode);
endinterface

// File: rtl/seg_scan_controller.sv
// Converts an 8-bit value to BCD by double-dabble and scans the three digits
// onto a 4-digit common-anode display through a shared BCD decoder.
module seg_scan_controller #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter bit          LEADING_BLANK = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  seg_scan_controller_if.slave bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 12;
  localparam int unsigned NW = 4;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t          state;
  logic [BW-1:0]   bin;
  logic [CW-1:0]   bcd;
  logic [CW-1:0]   bcd_adj_c;
  logic [NW-1:0]   step;
  logic            busy_r;
  logic [NW-1:0]   hund;
  logic [NW-1:0]   tens;
  logic [NW-1:0]   ones;
  logic [PW-1:0]   presc;
  logic [1:0]      slot;
  logic [NW-1:0]   slot_digit_c;
  logic            slot_blank_c;
  logic [NW-1:0]   digit_r;
  logic [NW-1:0]   anode_r;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion FSM; display registers change only in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      bin    <= '0;
      bcd    <= '0;
      step   <= '0;
      hund   <= '0;
      tens   <= '0;
      ones   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin    <= bus.value;
            bcd    <= '0;
            step   <= '0;
            busy_r <= 1'b1;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj_c[CW-2:0], bin, 1'b0};
          step       <= step + 4'd1;
          if (step == 4'd7) state <= COMMIT;
        end
        COMMIT: begin
          hund   <= bcd[11:8];
          tens   <= bcd[7:4];
          ones   <= bcd[3:0];
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running slot prescaler, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      slot  <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      slot  <= slot + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    slot_digit_c = '0;
    slot_blank_c = 1'b0;
    case (slot)
      2'd0: slot_digit_c = ones;
      2'd1: begin
        slot_digit_c = tens;
        slot_blank_c = LEADING_BLANK && (hund == 4'd0) && (tens == 4'd0);
      end
      2'd2: begin
        slot_digit_c = hund;
        slot_blank_c = LEADING_BLANK && (hund == 4'd0);
      end
      default: begin
        slot_digit_c = '0;
        slot_blank_c = 1'b1;
      end
    endcase
  end

  // Decoder digit and active-low anode, one register stage after the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_r <= '0;
      anode_r <= 4'b1111;
    end else begin
      digit_r <= slot_digit_c;
      anode_r <= slot_blank_c ? 4'b1111 : ~(4'b0001 << slot);
    end
  end

  assign bus.busy  = busy_r;
  assign bus.digit = digit_r;
  assign bus.anode = anode_r;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: three instances (DIV=4 blank, DIV=4 no blank, DIV=1 blank);
// every cycle the scanned outputs are compared against a cycle-count model.
module tb_seg_scan_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_controller_if bus0 ();
  seg_scan_controller_if bus1 ();
  seg_scan_controller_if bus2 ();

  seg_scan_controller #(.REFRESH_DIV(4), .LEADING_BLANK(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  seg_scan_controller #(.REFRESH_DIV(4), .LEADING_BLANK(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  seg_scan_controller #(.REFRESH_DIV(1), .LEADING_BLANK(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic       ld  [3];
  logic [7:0] val [3];
  logic       busy_a  [3];
  logic [3:0] digit_a [3];
  logic [3:0] anode_a [3];
  int         div_a [3] = '{4, 4, 1};
  bit         lb_a  [3] = '{1'b1, 1'b0, 1'b1};

  assign bus0.load = ld[0];  assign bus0.value = val[0];
  assign bus1.load = ld[1];  assign bus1.value = val[1];
  assign bus2.load = ld[2];  assign bus2.value = val[2];
  assign busy_a[0] = bus0.busy;  assign digit_a[0] = bus0.digit;  assign anode_a[0] = bus0.anode;
  assign busy_a[1] = bus1.busy;  assign digit_a[1] = bus1.digit;  assign anode_a[1] = bus1.anode;
  assign busy_a[2] = bus2.busy;  assign digit_a[2] = bus2.digit;  assign anode_a[2] = bus2.anode;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] q2[$];

  int          ncyc  [3];
  logic [11:0] shown [3];
  int          blen  [3];
  logic        pbusy [3];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %0h, expected %0h", name, i, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: per-cycle scan model, busy-length check and scoreboard pop on busy fall.
  always begin
    int          s;
    logic        blk;
    logic [3:0]  ed;
    logic [3:0]  ea;
    logic [11:0] d;
    logic [11:0] popped;
    int          qsz;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        check("reset_anode", i, 32'(anode_a[i]), 32'hF);
        check("reset_digit", i, 32'(digit_a[i]), 32'h0);
        check("reset_busy", i, 32'(busy_a[i]), 32'h0);
        ncyc[i] = 0; shown[i] = '0; blen[i] = 0; pbusy[i] = 1'b0;
        case (i)
          0: q0.delete();
          1: q1.delete();
          default: q2.delete();
        endcase
      end else begin
        ncyc[i]++;
        s = ((ncyc[i] - 1) / div_a[i]) % 4;
        d = shown[i];
        case (s)
          0: begin ed = d[3:0];  blk = 1'b0; end
          1: begin ed = d[7:4];  blk = lb_a[i] && d[11:4] == 8'd0; end
          2: begin ed = d[11:8]; blk = lb_a[i] && d[11:8] == 4'd0; end
          default: begin ed = 4'd0; blk = 1'b1; end
        endcase
        ea = blk ? 4'b1111 : ~(4'b0001 << s);
        check("scan_anode", i, 32'(anode_a[i]), 32'(ea));
        check("scan_digit", i, 32'(digit_a[i]), 32'(ed));
        if (busy_a[i]) begin
          blen[i]++;
        end else if (pbusy[i]) begin
          check("busy_len", i, 32'(blen[i]), 32'd9);
          case (i)
            0: qsz = q0.size();
            1: qsz = q1.size();
            default: qsz = q2.size();
          endcase
          check("sb_nonempty", i, 32'(qsz > 0), 32'd1);
          if (qsz > 0) begin
            case (i)
              0: popped = q0.pop_front();
              1: popped = q1.pop_front();
              default: popped = q2.pop_front();
            endcase
            shown[i] = popped;
          end
          blen[i] = 0;
        end
        pbusy[i] = busy_a[i];
      end
    end
  end

  task automatic do_load(input int i, input int v, input bit push);
    @(negedge clk);
    val[i] = 8'(v);
    ld[i]  = 1'b1;
    if (push) begin
      case (i)
        0: q0.push_back(to_bcd(v));
        1: q1.push_back(to_bcd(v));
        default: q2.push_back(to_bcd(v));
      endcase
    end
    @(negedge clk);
    ld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int c = 0;
    while (busy_a[i] && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", i, 32'(busy_a[i]), 32'd0);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ld[i] = 1'b0;
      val[i] = '0;
    end
    run(2);
    reset = 1'b0;
    run(20);

    do_load(0, 255, 1'b1);
    check("busy_after_load", 0, 32'(busy_a[0]), 32'd1);
    wait_idle(0); run(20);

    do_load(0, 7, 1'b1);   wait_idle(0); run(20);
    do_load(0, 100, 1'b1); wait_idle(0); run(20);

    do_load(0, 200, 1'b1);
    run(2);
    do_load(0, 99, 1'b0);
    wait_idle(0); run(20);
    do_load(0, 99, 1'b1);  wait_idle(0); run(20);

    do_load(0, 188, 1'b1);
    run(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("busy_after_reset", 0, 32'(busy_a[0]), 32'd0);
    run(18);
    do_load(0, 42, 1'b1);  wait_idle(0); run(20);

    // Align so COMMIT coincides with a slot-boundary edge.
    while ((ncyc[0] + 10) % 4 != 0) @(negedge clk);
    do_load(0, 123, 1'b1); wait_idle(0); run(20);

    do_load(1, 7, 1'b1);   wait_idle(1); run(20);
    do_load(2, 255, 1'b1); wait_idle(2); run(12);
    do_load(2, 30, 1'b1);  wait_idle(2); run(12);

    check("sb_drained0", 0, 32'(q0.size()), 32'd0);
    check("sb_drained1", 1, 32'(q1.size()), 32'd0);
    check("sb_drained2", 2, 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
